// File: rtl/bf16_pkg.sv
// bf16_pkg: shared constants, field helpers, FSM encoding and flag bundle
// for the BF16 arithmetic blocks (divider, multiplier).
//   BIAS       : BF16 exponent bias
//   QBITS      : quotient bits produced by the sequential divider
//   EXP_INF    : all-ones exponent (inf / NaN)
//   QNAN_CANON : canonical quiet NaN returned for every invalid case
package bf16_pkg;

   localparam int          QBITS      = 9;
   localparam int          BIAS       = 127;
   localparam logic [7:0]  EXP_INF    = 8'hFF;
   localparam logic [15:0] QNAN_CANON = 16'h7FC0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DIV  = 2'd1,
      S_NORM = 2'd2,
      S_DONE = 2'd3
   } div_state_e;

   typedef struct packed {
      logic zero;
      logic underflow;
      logic overflow;
      logic qnan;
      logic snan;
      logic pos_inf;
      logic neg_inf;
      logic div_by_zero;
   } div_flags_t;

   function automatic logic sign_of(input logic [15:0] v);
      return v[15];
   endfunction

   function automatic logic [7:0] exp_of(input logic [15:0] v);
      return v[14:7];
   endfunction

   function automatic logic [6:0] mant_of(input logic [15:0] v);
      return v[6:0];
   endfunction

endpackage

// File: rtl/bf16_classify.sv
// bf16_classify: combinational operand classifier.
//   op      in  16  BF16 operand
//   is_zero out 1   exponent 0 (subnormals flushed to zero)
//   is_inf  out 1   exponent all-ones, mantissa zero
//   is_qnan out 1   NaN with mantissa MSB set
//   is_snan out 1   NaN with mantissa MSB clear
module bf16_classify
   import bf16_pkg::*;
(
   input  logic [15:0] op,
   output logic        is_zero,
   output logic        is_inf,
   output logic        is_qnan,
   output logic        is_snan
);

   logic exp_max;
   logic mant_nz;

   assign exp_max = (exp_of(op) == EXP_INF);
   assign mant_nz = (mant_of(op) != 7'd0);

   assign is_zero = (exp_of(op) == 8'd0);
   assign is_inf  = exp_max & ~mant_nz;
   assign is_qnan = exp_max &  mant_nz &  op[6];
   assign is_snan = exp_max &  mant_nz & ~op[6];

endmodule

// File: rtl/bf16_seq_divider.sv
// bf16_seq_divider: iterative BF16 divider, result = num1 / num2.
// Restoring radix-2 mantissa division, one quotient bit per clock, then a
// single normalize cycle. Subnormals flush to zero, results truncate.
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready, num1, num2     operand handshake (in_ready = idle)
//   out_valid/out_ready, result       result handshake
//   zero, underflow, overflow, qNaN, sNaN, positive_inf, negative_inf,
//   div_by_zero                        status flags, registered with result
module bf16_seq_divider
   import bf16_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] num1,
   input  logic [15:0] num2,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] result,
   output logic        zero,
   output logic        underflow,
   output logic        overflow,
   output logic        qNaN,
   output logic        sNaN,
   output logic        positive_inf,
   output logic        negative_inf,
   output logic        div_by_zero
);

   div_state_e state, state_nxt;

   logic [3:0]        cnt;
   logic [8:0]        rem;
   logic [8:0]        q;
   logic [7:0]        m2_r;
   logic              sign_r;
   logic [9:0]        exp_base;   // exp1 - exp2 + BIAS, two's complement
   logic [15:0]       result_r;
   div_flags_t        flags_r;

   // operand classification on the live inputs: specials resolve at accept
   logic z1, i1, qn1, sn1;
   logic z2, i2, qn2, sn2;

   bf16_classify u_cls1 (.op(num1), .is_zero(z1), .is_inf(i1), .is_qnan(qn1), .is_snan(sn1));
   bf16_classify u_cls2 (.op(num2), .is_zero(z2), .is_inf(i2), .is_qnan(qn2), .is_snan(sn2));

   logic        s_in;
   logic        accept;
   logic        spec_hit;
   logic [15:0] spec_res;
   div_flags_t  spec_flags;

   assign s_in   = sign_of(num1) ^ sign_of(num2);
   assign accept = in_valid & (state == S_IDLE);

   always_comb begin
      spec_hit   = 1'b1;
      spec_res   = QNAN_CANON;
      spec_flags = '0;
      if (sn1 | sn2) begin
         spec_flags.snan = 1'b1;
      end else if (qn1 | qn2) begin
         spec_flags.qnan = 1'b1;
      end else if ((z1 & z2) | (i1 & i2)) begin
         spec_flags.qnan = 1'b1;
      end else if (i1) begin
         spec_res         = {s_in, EXP_INF, 7'h00};
         spec_flags.pos_inf = ~s_in;
         spec_flags.neg_inf = s_in;
      end else if (z2) begin
         spec_res             = {s_in, EXP_INF, 7'h00};
         spec_flags.pos_inf     = ~s_in;
         spec_flags.neg_inf     = s_in;
         spec_flags.div_by_zero = 1'b1;
      end else if (z1 | i2) begin
         spec_res        = {s_in, 15'h0000};
         spec_flags.zero = 1'b1;
      end else begin
         spec_hit = 1'b0;
      end
   end

   // one restoring step; remainder stays below 2*m2 so 9 bits suffice
   logic       q_bit;
   logic [8:0] diff;
   logic [8:0] rem_nxt;

   assign q_bit   = (rem >= {1'b0, m2_r});
   assign diff    = rem - (q_bit ? {1'b0, m2_r} : 9'd0);
   assign rem_nxt = {diff[7:0], 1'b0};

   // normalize: quotient lies in [0.5, 2), so at most one left shift
   logic [6:0]  norm_mant;
   logic [9:0]  e_norm;
   logic [15:0] norm_res;
   div_flags_t  norm_flags;

   assign norm_mant = q[8] ? q[7:1] : q[6:0];
   assign e_norm    = q[8] ? exp_base : exp_base - 10'd1;

   always_comb begin
      norm_flags = '0;
      norm_res   = {sign_r, e_norm[7:0], norm_mant};
      if ($signed(e_norm) >= 10'sd255) begin
         norm_res           = {sign_r, EXP_INF, 7'h00};
         norm_flags.overflow = 1'b1;
         norm_flags.pos_inf  = ~sign_r;
         norm_flags.neg_inf  = sign_r;
      end else if ($signed(e_norm) <= 10'sd0) begin
         norm_res             = {sign_r, 15'h0000};
         norm_flags.underflow = 1'b1;
         norm_flags.zero      = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (in_valid) state_nxt = spec_hit ? S_DONE : S_DIV;
         S_DIV:  if (cnt == 4'(QBITS - 1)) state_nxt = S_NORM;
         S_NORM: state_nxt = S_DONE;
         S_DONE: if (out_ready) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         rem      <= '0;
         q        <= '0;
         m2_r     <= '0;
         sign_r   <= 1'b0;
         exp_base <= '0;
         result_r <= '0;
         flags_r  <= '0;
      end else begin
         case (state)
            S_IDLE: if (accept) begin
               cnt      <= '0;
               q        <= '0;
               rem      <= {2'b01, mant_of(num1)};
               m2_r     <= {1'b1, mant_of(num2)};
               sign_r   <= s_in;
               exp_base <= {2'b00, exp_of(num1)} - {2'b00, exp_of(num2)} + 10'(BIAS);
               if (spec_hit) begin
                  result_r <= spec_res;
                  flags_r  <= spec_flags;
               end
            end
            S_DIV: begin
               q   <= {q[7:0], q_bit};
               rem <= rem_nxt;
               cnt <= cnt + 4'd1;
            end
            S_NORM: begin
               result_r <= norm_res;
               flags_r  <= norm_flags;
            end
            S_DONE: if (out_ready) flags_r <= '0;
            default: ;
         endcase
      end
   end

   assign in_ready     = (state == S_IDLE);
   assign out_valid    = (state == S_DONE);
   assign result       = result_r;
   assign zero         = flags_r.zero;
   assign underflow    = flags_r.underflow;
   assign overflow     = flags_r.overflow;
   assign qNaN         = flags_r.qnan;
   assign sNaN         = flags_r.snan;
   assign positive_inf = flags_r.pos_inf;
   assign negative_inf = flags_r.neg_inf;
   assign div_by_zero  = flags_r.div_by_zero;

endmodule

// File: tb/tb_bf16_seq_divider.sv
// tb_bf16_seq_divider: directed + random checks of bf16_seq_divider against
// an arithmetic reference model (integer quotient of the significands).
// Flag vector order: {zero,underflow,overflow,qNaN,sNaN,pos_inf,neg_inf,dbz}.
module tb_bf16_seq_divider;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] num1, num2;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;
   logic        zero, underflow, overflow, qNaN, sNaN;
   logic        positive_inf, negative_inf, div_by_zero;
   logic [7:0]  flags_v;

   int n_checks = 0;
   int n_fail   = 0;

   bf16_seq_divider dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .num1(num1), .num2(num2),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result),
      .zero(zero), .underflow(underflow), .overflow(overflow),
      .qNaN(qNaN), .sNaN(sNaN),
      .positive_inf(positive_inf), .negative_inf(negative_inf),
      .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   assign flags_v = {zero, underflow, overflow, qNaN, sNaN,
                     positive_inf, negative_inf, div_by_zero};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: {special, flags[7:0], result[15:0]}
   function automatic logic [24:0] ref_div(input logic [15:0] a, input logic [15:0] b);
      logic s;
      int   ea, eb, ma, mb, qv, e, mant;
      logic za, zb, ia, ib, qa, qb, sa, sb;
      logic [7:0]  fl;
      logic [15:0] r;
      s  = a[15] ^ b[15];
      ea = int'(a[14:7]); eb = int'(b[14:7]);
      ma = int'(a[6:0]);  mb = int'(b[6:0]);
      za = (ea == 0); zb = (eb == 0);
      ia = (ea == 255) && (ma == 0); ib = (eb == 255) && (mb == 0);
      qa = (ea == 255) && (ma >= 64); qb = (eb == 255) && (mb >= 64);
      sa = (ea == 255) && (ma != 0) && (ma < 64);
      sb = (eb == 255) && (mb != 0) && (mb < 64);
      fl = 8'h00;
      r  = 16'h7FC0;
      if (sa || sb)                    fl = 8'b0000_1000;
      else if (qa || qb)               fl = 8'b0001_0000;
      else if ((za && zb) || (ia && ib)) fl = 8'b0001_0000;
      else if (ia) begin
         r = {s, 15'h7F80}; fl = s ? 8'b0000_0010 : 8'b0000_0100;
      end else if (zb) begin
         r = {s, 15'h7F80}; fl = s ? 8'b0000_0011 : 8'b0000_0101;
      end else if (za || ib) begin
         r = {s, 15'h0000}; fl = 8'b1000_0000;
      end else begin
         // truncated quotient with 8 fraction bits
         qv = ((128 + ma) * 256) / (128 + mb);
         e  = ea - eb + 127;
         if (qv >= 256) mant = (qv / 2) % 128;
         else begin mant = qv % 128; e = e - 1; end
         if (e >= 255) begin
            r = {s, 15'h7F80}; fl = s ? 8'b0010_0010 : 8'b0010_0100;
         end else if (e <= 0) begin
            r = {s, 15'h0000}; fl = 8'b1100_0000;
         end else begin
            r = {s, e[7:0], mant[6:0]};
         end
         return {1'b0, fl, r};
      end
      return {1'b1, fl, r};
   endfunction

   function automatic logic [15:0] rand_op();
      int k;
      logic [7:0] e;
      logic [6:0] m;
      k = $urandom_range(0, 15);
      m = 7'($urandom);
      case (k)
         0:       e = 8'h00;
         1:       e = 8'hFF;
         2:       begin e = 8'($urandom_range(240, 254)); end
         3:       begin e = 8'($urandom_range(1, 14)); end
         4:       begin e = 8'hFF; m = 7'h00; end
         default: e = 8'($urandom_range(100, 154));
      endcase
      return {1'($urandom), e, m};
   endfunction

   // Issue one operation, check result/flags/latency, then complete handshake.
   task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_res, input logic [7:0] exp_fl,
                        input int exp_lat);
      int w, lat;
      w = 0;
      while (!in_ready && w < 40) begin @(posedge clk); #1; w++; end
      check({tag, " in_ready"}, 32'(in_ready), 32'd1);
      num1 = a; num2 = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 30) begin @(posedge clk); #1; lat++; end
      check({tag, " out_valid"}, 32'(out_valid), 32'd1);
      check({tag, " result"},    32'(result),    32'(exp_res));
      check({tag, " flags"},     32'(flags_v),   32'(exp_fl));
      check({tag, " latency"},   32'(lat),       32'(exp_lat));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, " flags clr"}, 32'(flags_v), 32'd0);
   endtask

   task automatic do_rand_op(input logic [15:0] a, input logic [15:0] b);
      logic [24:0] m;
      m = ref_div(a, b);
      do_op($sformatf("rnd %h/%h", a, b), a, b, m[15:0], m[23:16], m[24] ? 1 : 11);
   endtask

   initial begin
      int lat;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; num1 = '0; num2 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset in_ready",  32'(in_ready),  32'd1);
      check("reset out_valid", 32'(out_valid), 32'd0);
      check("reset result",    32'(result),    32'd0);
      check("reset flags",     32'(flags_v),   32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      do_op("3/1",     16'h4040, 16'h3F80, 16'h4040, 8'h00, 11);
      do_op("1/3",     16'h3F80, 16'h4040, 16'h3EAA, 8'h00, 11);
      do_op("6/-2",    16'h40C0, 16'hC000, 16'hC040, 8'h00, 11);
      do_op("1/0",     16'h3F80, 16'h0000, 16'h7F80, 8'b0000_0101, 1);
      do_op("0/0",     16'h0000, 16'h0000, 16'h7FC0, 8'b0001_0000, 1);
      do_op("ovf",     16'h7F00, 16'h0080, 16'h7F80, 8'b0010_0100, 11);
      do_op("unf",     16'h0080, 16'h7F00, 16'h0000, 8'b1100_0000, 11);
      do_op("snan",    16'h7F81, 16'h3F80, 16'h7FC0, 8'b0000_1000, 1);
      do_op("-inf/2",  16'hFF80, 16'h4000, 16'hFF80, 8'b0000_0010, 1);
      do_op("1/-inf",  16'h3F80, 16'hFF80, 16'h8000, 8'b1000_0000, 1);

      // backpressure: result held, second request ignored until handshake
      num1 = 16'h4040; num2 = 16'h3F80; in_valid = 1'b1;
      @(posedge clk); #1;
      num1 = 16'h3F80; num2 = 16'h4040;
      lat = 1;
      while (!out_valid && lat < 30) begin @(posedge clk); #1; lat++; end
      check("bp first latency", 32'(lat), 32'd11);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp out_valid", 32'(out_valid), 32'd1);
         check("bp result",    32'(result),    32'h4040);
         check("bp flags",     32'(flags_v),   32'd0);
         check("bp in_ready",  32'(in_ready),  32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("bp released out_valid", 32'(out_valid), 32'd0);
      check("bp released in_ready",  32'(in_ready),  32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 30) begin @(posedge clk); #1; lat++; end
      check("bp second latency", 32'(lat),    32'd11);
      check("bp second result",  32'(result), 32'h3EAA);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      // reset in the middle of the division
      num1 = 16'h40C0; num2 = 16'hC000; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst out_valid", 32'(out_valid), 32'd0);
      check("midrst in_ready",  32'(in_ready),  32'd1);
      check("midrst flags",     32'(flags_v),   32'd0);
      check("midrst result",    32'(result),    32'd0);
      repeat (12) begin
         @(posedge clk); #1;
         check("midrst no output", 32'(out_valid), 32'd0);
      end
      do_op("after rst", 16'h40C0, 16'hC000, 16'hC040, 8'h00, 11);

      for (int i = 0; i < 60; i++) do_rand_op(rand_op(), rand_op());

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
